ttt_referee: RTL and testbench

//  Downstream judge of square_status. After each committed move it snapshots the nine
//  3-bit square statuses, scans the 8 win lines one per clock, and reports win/draw.
//  If the game continues, it toggles player_turn, which feeds back into square_status.

---
 rtl/ttt_referee.sv | 191 +++++++++++++++++++
 tb/tb_ttt_referee.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_referee.sv
// ttt_referee: judges a tic-tac-toe board after each committed move.
// The nine square statuses are snapshotted on a move, the eight win lines are
// scanned one per clock, and the result (win, draw or next turn) is reported.
module ttt_referee #(
   parameter logic [2:0] P1_MARK   = 3'd1,
   parameter logic [2:0] P2_MARK   = 3'd2,
   parameter int unsigned MAX_MOVES = 9
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       new_game,
   input  logic       move_done,
   input  logic [2:0] square_1,
   input  logic [2:0] square_2,
   input  logic [2:0] square_3,
   input  logic [2:0] square_4,
   input  logic [2:0] square_5,
   input  logic [2:0] square_6,
   input  logic [2:0] square_7,
   input  logic [2:0] square_8,
   input  logic [2:0] square_9,
   output logic       player_turn,
   output logic       busy,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [3:0] win_line,
   output logic [3:0] move_count,
   output logic       move_ignored
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_MOVES);

   typedef enum logic [1:0] {
      ST_PLAY   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [8:0][2:0] snap_q, snap_d;
   logic [2:0]      line_idx_q, line_idx_d;
   logic            player_turn_q, player_turn_d;
   logic [1:0]      winner_q, winner_d;
   logic [3:0]      win_line_q, win_line_d;
   logic [3:0]      move_count_q, move_count_d;
   logic            move_ignored_q, move_ignored_d;

   logic [8:0][2:0] squares_s;
   logic [1:0]      hit_s;

   // Returns 1 or 2 when line idx holds three matching player marks, else 0.
   // Codes other than the two player marks never form a line.
   function automatic logic [1:0] judge_line(input logic [8:0][2:0] snap,
                                             input logic [2:0]      idx);
      logic [2:0] a, b, c;
      case (idx)
         3'd0:    begin a = snap[0]; b = snap[1]; c = snap[2]; end
         3'd1:    begin a = snap[3]; b = snap[4]; c = snap[5]; end
         3'd2:    begin a = snap[6]; b = snap[7]; c = snap[8]; end
         3'd3:    begin a = snap[0]; b = snap[3]; c = snap[6]; end
         3'd4:    begin a = snap[1]; b = snap[4]; c = snap[7]; end
         3'd5:    begin a = snap[2]; b = snap[5]; c = snap[8]; end
         3'd6:    begin a = snap[0]; b = snap[4]; c = snap[8]; end
         3'd7:    begin a = snap[2]; b = snap[4]; c = snap[6]; end
         default: begin a = snap[2]; b = snap[4]; c = snap[6]; end
      endcase
      if ((a == b) && (b == c) && (a == P1_MARK)) begin
         judge_line = 2'd1;
      end else if ((a == b) && (b == c) && (a == P2_MARK)) begin
         judge_line = 2'd2;
      end else begin
         judge_line = 2'd0;
      end
   endfunction

   assign squares_s = {square_9, square_8, square_7, square_6, square_5,
                       square_4, square_3, square_2, square_1};
   assign hit_s     = judge_line(snap_q, line_idx_q);

   // State and datapath registers; clr returns everything to the idle game.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q        <= ST_PLAY;
         snap_q         <= '0;
         line_idx_q     <= 3'd0;
         player_turn_q  <= 1'b0;
         winner_q       <= 2'd0;
         win_line_q     <= 4'd0;
         move_count_q   <= 4'd0;
         move_ignored_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         snap_q         <= snap_d;
         line_idx_q     <= line_idx_d;
         player_turn_q  <= player_turn_d;
         winner_q       <= winner_d;
         win_line_q     <= win_line_d;
         move_count_q   <= move_count_d;
         move_ignored_q <= move_ignored_d;
      end
   end

   // Next-state logic: accept moves in PLAY, scan lines, then decide turn/draw.
   always_comb begin
      state_d        = state_q;
      snap_d         = snap_q;
      line_idx_d     = line_idx_q;
      player_turn_d  = player_turn_q;
      winner_d       = winner_q;
      win_line_d     = win_line_q;
      move_count_d   = move_count_q;
      move_ignored_d = 1'b0;
      if (new_game) begin
         state_d       = ST_PLAY;
         snap_d        = '0;
         line_idx_d    = 3'd0;
         player_turn_d = 1'b0;
         winner_d      = 2'd0;
         win_line_d    = 4'd0;
         move_count_d  = 4'd0;
      end else begin
         case (state_q)
            ST_PLAY: begin
               if (move_done) begin
                  snap_d     = squares_s;
                  line_idx_d = 3'd0;
                  state_d    = ST_SCAN;
                  if (move_count_q < MAX_CNT) begin
                     move_count_d = move_count_q + 4'd1;
                  end else begin
                     move_count_d = move_count_q;
                  end
               end else begin
                  state_d = ST_PLAY;
               end
            end
            ST_SCAN: begin
               move_ignored_d = move_done;
               if (hit_s != 2'd0) begin
                  winner_d   = hit_s;
                  win_line_d = {1'b0, line_idx_q} + 4'd1;
                  state_d    = ST_OVER;
               end else if (line_idx_q == 3'd7) begin
                  state_d = ST_UPDATE;
               end else begin
                  line_idx_d = line_idx_q + 3'd1;
               end
            end
            ST_UPDATE: begin
               move_ignored_d = move_done;
               if (move_count_q == MAX_CNT) begin
                  winner_d   = 2'd3;
                  win_line_d = 4'd0;
                  state_d    = ST_OVER;
               end else begin
                  player_turn_d = ~player_turn_q;
                  state_d       = ST_PLAY;
               end
            end
            ST_OVER: begin
               move_ignored_d = move_done;
            end
            default: begin
               state_d = ST_PLAY;
            end
         endcase
      end
   end

   // Output decode: status flags come straight from the state register.
   always_comb begin
      busy      = 1'b0;
      game_over = 1'b0;
      case (state_q)
         ST_SCAN, ST_UPDATE: busy      = 1'b1;
         ST_OVER:            game_over = 1'b1;
         default: begin
            busy      = 1'b0;
            game_over = 1'b0;
         end
      endcase
   end

   assign player_turn  = player_turn_q;
   assign winner       = winner_q;
   assign win_line     = win_line_q;
   assign move_count   = move_count_q;
   assign move_ignored = move_ignored_q;

endmodule

// File: tb/tb_ttt_referee.sv
// Bench for ttt_referee: directed game scenarios plus random games, all
// checked against a game-level model built from the line table.
module tb_ttt_referee;

   logic       clk = 1'b0;
   logic       clr, new_game, move_done;
   logic [2:0] sq [9];
   logic       player_turn, busy, game_over, move_ignored;
   logic [1:0] winner;
   logic [3:0] win_line, move_count;

   always #5 clk = ~clk;

   ttt_referee dut (
      .clk(clk), .clr(clr), .new_game(new_game), .move_done(move_done),
      .square_1(sq[0]), .square_2(sq[1]), .square_3(sq[2]),
      .square_4(sq[3]), .square_5(sq[4]), .square_6(sq[5]),
      .square_7(sq[6]), .square_8(sq[7]), .square_9(sq[8]),
      .player_turn(player_turn), .busy(busy), .game_over(game_over),
      .winner(winner), .win_line(win_line), .move_count(move_count),
      .move_ignored(move_ignored)
   );

   int checks = 0;
   int failures = 0;

   // Game-level model
   int board [9];
   bit used [9];
   bit m_turn, m_over;
   int m_count, m_winner, m_line;
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic int first_hit();
      for (int i = 0; i < 8; i++) begin
         int a, b, c;
         a = board[lines[i][0]]; b = board[lines[i][1]]; c = board[lines[i][2]];
         if (a == b && b == c && (a == 1 || a == 2)) return i;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".turn"},   32'(player_turn), 32'(m_turn));
      check({tag, ".count"},  32'(move_count),  32'(m_count));
      check({tag, ".over"},   32'(game_over),   32'(m_over));
      check({tag, ".winner"}, 32'(winner),      32'(m_winner));
      check({tag, ".line"},   32'(win_line),    32'(m_line));
      check({tag, ".busy"},   32'(busy),        32'd0);
   endtask

   task automatic reset_model();
      m_turn = 1'b0; m_over = 1'b0; m_count = 0; m_winner = 0; m_line = 0;
      for (int i = 0; i < 9; i++) begin
         board[i] = 0; used[i] = 1'b0; sq[i] = 3'd0;
      end
   endtask

   task automatic do_new_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      reset_model();
      check_outputs("new_game");
      check("new_game.ignored", 32'(move_ignored), 32'd0);
   endtask

   // Present the model board, pulse move_done, follow the judgement to its end.
   task automatic do_move(input bit scramble);
      int hit;
      for (int i = 0; i < 9; i++) sq[i] = 3'(board[i]);
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      if (m_over) begin
         check("ignored.pulse", 32'(move_ignored), 32'd1);
         tick();
         check("ignored.drop", 32'(move_ignored), 32'd0);
         check_outputs("frozen");
      end else begin
         if (m_count < 9) m_count++;
         check("accept.busy",    32'(busy),         32'd1);
         check("accept.count",   32'(move_count),   32'(m_count));
         check("accept.ignored", 32'(move_ignored), 32'd0);
         if (scramble) begin
            for (int i = 0; i < 9; i++) sq[i] = 3'($urandom_range(0, 7));
         end
         hit = first_hit();
         if (hit >= 0) begin
            repeat (hit) tick();
            check("scan.busy", 32'(busy), 32'd1);
            check("scan.over", 32'(game_over), 32'd0);
            tick();
            m_over   = 1'b1;
            m_winner = (board[lines[hit][0]] == 1) ? 1 : 2;
            m_line   = hit + 1;
            check_outputs("win");
         end else begin
            repeat (8) tick();
            check("update.busy", 32'(busy), 32'd1);
            tick();
            if (m_count == 9) begin
               m_over = 1'b1; m_winner = 3; m_line = 0;
            end else begin
               m_turn = ~m_turn;
            end
            check_outputs("judged");
         end
      end
   endtask

   task automatic place(input int idx, input int code);
      board[idx] = code;
      used[idx]  = 1'b1;
      do_move(1'b1);
   endtask

   task automatic place_turn(input int idx);
      place(idx, m_turn ? 2 : 1);
   endtask

   initial begin
      int order9 [9];
      int order5 [9];
      clr = 1'b1; new_game = 1'b0; move_done = 1'b0;
      reset_model();
      #12;
      check_outputs("reset");
      check("reset.ignored", 32'(move_ignored), 32'd0);
      clr = 1'b0;
      tick();
      check_outputs("post_reset");

      // Blank board: full 9-cycle judgement then turn passes to player 2
      do_move(1'b0);

      // Top row of player 1 marks: hit on line 0
      do_new_game();
      board[0] = 1; board[1] = 1; board[2] = 1;
      do_move(1'b0);

      // Anti-diagonal of player 2 marks: hit on the last line; then ignored move
      do_new_game();
      board[2] = 2; board[4] = 2; board[6] = 2;
      do_move(1'b1);
      do_move(1'b0);

      // Codes 3 and 7 never form a line
      do_new_game();
      board[0] = 3; board[1] = 3; board[2] = 3;
      board[6] = 7; board[7] = 7; board[8] = 7;
      do_move(1'b0);

      // Full board without a line: draw on the 9th move
      do_new_game();
      order9 = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      foreach (order9[i]) place_turn(order9[i]);
      check("draw.winner", 32'(winner), 32'd3);

      // 9th move completes the main diagonal: a win, not a draw
      do_new_game();
      order5 = '{0, 1, 2, 3, 4, 5, 7, 6, 8};
      foreach (order5[i]) place_turn(order5[i]);
      check("win9.line", 32'(win_line), 32'd7);

      // move_done three cycles into a scan is dropped
      do_new_game();
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      m_count = 1;
      check("midscan.count0", 32'(move_count), 32'd1);
      tick(); tick();
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      check("midscan.ignored", 32'(move_ignored), 32'd1);
      check("midscan.count1",  32'(move_count),   32'd1);
      tick();
      check("midscan.pulse_end", 32'(move_ignored), 32'd0);
      repeat (5) tick();
      m_turn = 1'b1;
      check_outputs("midscan.done");

      // clr in the middle of a scan discards the judgement immediately
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      tick(); tick();
      clr = 1'b1;
      #1;
      reset_model();
      check_outputs("clr_midscan");
      clr = 1'b0;
      tick();
      check_outputs("clr_after");
      do_move(1'b0);

      // Random games with random square order and occasional invalid codes
      for (int g = 0; g < 30; g++) begin
         do_new_game();
         while (!m_over) begin
            int idx;
            idx = $urandom_range(0, 8);
            while (used[idx]) idx = (idx + 1) % 9;
            if ($urandom_range(0, 7) == 0) place(idx, $urandom_range(3, 7));
            else place_turn(idx);
         end
         do_move(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
